mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH, request address width.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH, read/write data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive LSU grants allowed while fetch waits (range 1-15).
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_req  input  1  fetch request valid, held until granted.
REQ-007 fetch_addr  input  ADDR_WIDTH  fetch address.
REQ-008 fetch_flush  input  1  branch flush; cancels pending fetch.
REQ-009 fetch_grant  output  1  one-cycle fetch grant pulse.
REQ-010 fetch_data_valid  output  1  fetch read data valid pulse.
REQ-011 fetch_data  output  DATA_WIDTH  fetch read data.
REQ-012 lsu_req  input  1  load/store request valid, held until granted.
REQ-013 lsu_we  input  1  1 = store, 0 = load.
REQ-014 lsu_addr  input  ADDR_WIDTH  load/store address.
REQ-015 lsu_wdata  input  DATA_WIDTH  store data.
REQ-016 lsu_grant  output  1  one-cycle LSU grant pulse.
REQ-017 lsu_data_valid  output  1  load data / store-complete pulse.
REQ-018 lsu_data  output  DATA_WIDTH  load read data.
REQ-019 mem_stall  output  1  to fetch: LSU request pending or LSU transaction in flight.
REQ-020 mem_req  output  1  one-cycle memory request pulse.
REQ-021 mem_we, mem_addr, mem_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  memory command, valid with mem_req.
REQ-022 mem_rvalid  input  1  memory response pulse (reads and writes).
REQ-023 mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_rvalid.

Function
REQ-024 FSM states IDLE, FETCH_BUSY, LSU_BUSY; at most one transaction outstanding.
REQ-025 In IDLE, arbitration is combinational: grant pulse, mem_req and command asserted in the same cycle the request is seen; state moves to *_BUSY next cycle.
REQ-026 Priority: LSU beats fetch unless starve_cnt == STARVE_LIMIT and fetch_req is high, in which case fetch wins.
REQ-027 starve_cnt (4 bits) increments on each lsu_grant while fetch_req is high, saturates at STARVE_LIMIT, clears on fetch_grant or when fetch_req is low.
REQ-028 fetch_req with fetch_flush high in the same IDLE cycle is not granted.
REQ-029 In *_BUSY, no grants issued; requests ignored; mem_req low.
REQ-030 On mem_rvalid in FETCH_BUSY: fetch_data <= mem_rdata, fetch_data_valid pulses for one cycle, state -> IDLE.
REQ-031 On mem_rvalid in LSU_BUSY: lsu_data <= mem_rdata (loads), lsu_data_valid pulses, state -> IDLE.
REQ-032 Response data/valid outputs are registered: valid pulse appears the cycle after mem_rvalid.
REQ-033 fetch_flush during FETCH_BUSY (or on the mem_rvalid cycle) sets drop flag; matching response completes the FSM but fetch_data_valid stays low; drop clears on return to IDLE.
REQ-034 Back-to-back: a new grant is permitted in the first IDLE cycle after mem_rvalid (minimum 2 cycles between grants).
REQ-035 mem_rvalid in IDLE is ignored (no valid output, no state change).
REQ-036 mem_stall = lsu_req | (state == LSU_BUSY), combinational.
REQ-037 Neither grant nor data_valid is ever asserted for both requesters in the same cycle.

Reset
REQ-038 On reset: state IDLE, starve_cnt 0, drop flag 0, all grant/valid/mem_req outputs 0, fetch_data and lsu_data 0.
REQ-039 Reset mid-transaction abandons it; a later mem_rvalid in IDLE is ignored per REQ-035.

Verification
REQ-040 fetch_req, addr 0x40, memory returns 0x00000013 after 3 cycles -> fetch_grant cycle 0, mem_addr 0x40, fetch_data_valid with 0x00000013 one cycle after mem_rvalid.
REQ-041 fetch_req and lsu_req (store 0x80, data 0xDEADBEEF) same cycle -> lsu_grant, mem_we 1, mem_stall 1; fetch granted after store completes.
REQ-042 lsu_req continuous, fetch_req held, STARVE_LIMIT 4 -> 4 lsu grants then 1 fetch grant, then lsu resumes.
REQ-043 fetch granted, fetch_flush pulsed in FETCH_BUSY -> response consumed, fetch_data_valid never asserts, next request granted normally.
REQ-044 reset asserted in LSU_BUSY, mem_rvalid arrives after reset -> no lsu_data_valid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and the load/store unit.
// LSU has priority; a saturating starvation counter guarantees fetch eventually wins.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
    parameter int          ADDR_WIDTH   = `ADDR_WIDTH,
    parameter int          DATA_WIDTH   = `DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_grant,
    output logic                  fetch_data_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,

    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_grant,
    output logic                  lsu_data_valid,
    output logic [DATA_WIDTH-1:0] lsu_data,

    output logic                  mem_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_BUSY = 2'd1,
        LSU_BUSY   = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  drop_q, drop_d;
    logic                  lsu_we_q, lsu_we_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  lsu_valid_q, lsu_valid_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;

    logic idle;
    logic starved;

    // Grants are decided combinationally in IDLE so the command leaves in the request cycle.
    assign idle        = (state_q == IDLE);
    assign starved     = fetch_req && (starve_q == STARVE_MAX);
    assign fetch_grant = idle && fetch_req && !fetch_flush && (!lsu_req || starved);
    assign lsu_grant   = idle && lsu_req && !fetch_grant;

    assign mem_req   = fetch_grant | lsu_grant;
    assign mem_we    = lsu_grant & lsu_we;
    assign mem_addr  = lsu_grant ? lsu_addr : (fetch_grant ? fetch_addr : '0);
    assign mem_wdata = lsu_grant ? lsu_wdata : '0;
    assign mem_stall = lsu_req | (state_q == LSU_BUSY);

    assign fetch_data_valid = fetch_valid_q;
    assign fetch_data       = fetch_data_q;
    assign lsu_data_valid   = lsu_valid_q;
    assign lsu_data         = lsu_data_q;

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        drop_d        = drop_q;
        lsu_we_d      = lsu_we_q;
        fetch_valid_d = 1'b0;
        lsu_valid_d   = 1'b0;
        fetch_data_d  = fetch_data_q;
        lsu_data_d    = lsu_data_q;

        if (fetch_grant || !fetch_req) begin
            starve_d = 4'd0;
        end else if (lsu_grant && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (fetch_grant) begin
                    state_d = FETCH_BUSY;
                end else if (lsu_grant) begin
                    state_d  = LSU_BUSY;
                    lsu_we_d = lsu_we;
                end
            end
            FETCH_BUSY: begin
                // A flush on the response cycle itself must still suppress delivery.
                if (mem_rvalid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q && !fetch_flush) begin
                        fetch_valid_d = 1'b1;
                        fetch_data_d  = mem_rdata;
                    end
                end else if (fetch_flush) begin
                    drop_d = 1'b1;
                end
            end
            LSU_BUSY: begin
                if (mem_rvalid) begin
                    state_d     = IDLE;
                    lsu_valid_d = 1'b1;
                    if (!lsu_we_q) begin
                        lsu_data_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            starve_q      <= 4'd0;
            drop_q        <= 1'b0;
            lsu_we_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            lsu_valid_q   <= 1'b0;
            fetch_data_q  <= '0;
            lsu_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            drop_q        <= drop_d;
            lsu_we_q      <= lsu_we_d;
            fetch_valid_q <= fetch_valid_d;
            lsu_valid_q   <= lsu_valid_d;
            fetch_data_q  <= fetch_data_d;
            lsu_data_q    <= lsu_data_d;
        end
    end

endmodule
